// File: rtl/pipeline_dmem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_dmem_bridge_pkg
// Purpose  : Shared FSM state encoding and load/store format codes.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/pipeline_dmem_bridge_align.sv
`default_nettype none
// ============================================================================
// Module   : load_store_align
// Purpose  : Byte-lane steering for stores, lane extraction and extension for loads.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_align
  import pipeline_dmem_bridge_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] store_lanes_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  w_byte_sel;
  logic [15:0] w_half_sel;

  assign w_byte_sel = load_word_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half_sel = load_word_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    byte_en_o     = 4'b1111;
    store_lanes_o = store_data_i;
    load_data_o   = load_word_i;
    case (fmt_i)
      FMT_B, FMT_BU: begin
        byte_en_o     = 4'b0001 << addr_lo_i;
        store_lanes_o = {4{store_data_i[7:0]}};
        load_data_o   = {{24{(fmt_i == FMT_B) & w_byte_sel[7]}}, w_byte_sel};
      end
      FMT_H, FMT_HU: begin
        // Halfword lanes follow addr[1] only; addr[0] is silently dropped.
        byte_en_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
        store_lanes_o = {2{store_data_i[15:0]}};
        load_data_o   = {{16{(fmt_i == FMT_H) & w_half_sel[15]}}, w_half_sel};
      end
      FMT_W: begin
        byte_en_o     = 4'b1111;
        store_lanes_o = store_data_i;
        load_data_o   = load_word_i;
      end
      default: begin
        byte_en_o     = 4'b1111;
        store_lanes_o = store_data_i;
        load_data_o   = load_word_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_dmem_bridge
// Purpose  : MEM-stage to valid/ready memory bus bridge with pipeline stall.
//            Optional one-entry store buffer: define DMEM_WRITE_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_dmem_bridge
  import pipeline_dmem_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_write_data,
  input  logic [2:0]  data_mem_format,
  output logic [31:0] data_mem_read_data,
  output logic        want_stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_address,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_byte_enable,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  fmt_q, fmt_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        w_access;
  logic [31:0] w_load_data;
`ifdef DMEM_WRITE_BUFFER_EN
  logic        buf_q, buf_d;
`endif

  load_store_align u_align (
    .fmt_i         (fmt_q),
    .addr_lo_i     (addr_q[1:0]),
    .store_data_i  (wdata_q),
    .load_word_i   (bus_resp_rdata),
    .byte_en_o     (bus_req_byte_enable),
    .store_lanes_o (bus_req_wdata),
    .load_data_o   (w_load_data)
  );

  assign w_access           = data_mem_read_enable | data_mem_write_enable;
  assign bus_req_valid      = (state_q == ST_REQ);
  assign bus_req_write      = write_q;
  assign bus_req_address    = {addr_q[31:2], 2'b00};
  assign data_mem_read_data = rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fmt_q   <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fmt_q   <= fmt_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_WRITE_BUFFER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fmt_d      = fmt_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    want_stall = 1'b0;
`ifdef DMEM_WRITE_BUFFER_EN
    buf_d      = buf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_access) begin
          addr_d     = data_mem_address;
          wdata_d    = data_mem_write_data;
          fmt_d      = data_mem_format;
          write_d    = data_mem_write_enable;
          state_d    = ST_REQ;
          want_stall = 1'b1;
`ifdef DMEM_WRITE_BUFFER_EN
          if (data_mem_write_enable) begin
            buf_d      = 1'b1;
            want_stall = 1'b0;
          end
`endif
        end
      end
      ST_REQ: begin
        want_stall = 1'b1;
        if (bus_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        want_stall = 1'b1;
        if (bus_resp_valid) begin
          if (!write_q) rdata_d = w_load_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef DMEM_WRITE_BUFFER_EN
    // A buffered store drains in the background; only a new access has to wait for its ack.
    if (buf_q) begin
      want_stall = w_access;
      if ((state_q == ST_WAIT) && bus_resp_valid) begin
        buf_d   = 1'b0;
        state_d = ST_IDLE;
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_dmem_bridge
// Purpose  : Directed self-checking bench for pipeline_dmem_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_dmem_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        data_mem_read_enable = 1'b0;
  logic        data_mem_write_enable = 1'b0;
  logic [31:0] data_mem_address = '0;
  logic [31:0] data_mem_write_data = '0;
  logic [2:0]  data_mem_format = '0;
  logic [31:0] data_mem_read_data;
  logic        want_stall;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_write;
  logic [31:0] bus_req_address;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_byte_enable;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_resp_rdata = '0;

  int checks = 0;
  int errors = 0;

  int          r_stalls;
  logic [3:0]  r_be;
  logic [31:0] r_wd, r_adr, r_res;
  logic        r_wr, r_stable, r_tmo;

  pipeline_dmem_bridge dut (
    .clock                (clock),
    .reset                (reset),
    .data_mem_read_enable (data_mem_read_enable),
    .data_mem_write_enable(data_mem_write_enable),
    .data_mem_address     (data_mem_address),
    .data_mem_write_data  (data_mem_write_data),
    .data_mem_format      (data_mem_format),
    .data_mem_read_data   (data_mem_read_data),
    .want_stall           (want_stall),
    .bus_req_valid        (bus_req_valid),
    .bus_req_ready        (bus_req_ready),
    .bus_req_write        (bus_req_write),
    .bus_req_address      (bus_req_address),
    .bus_req_wdata        (bus_req_wdata),
    .bus_req_byte_enable  (bus_req_byte_enable),
    .bus_resp_valid       (bus_resp_valid),
    .bus_resp_rdata       (bus_resp_rdata)
  );

  always #5 clock = ~clock;

  // Runs one access against a memory that waits rdy_wait cycles before ready and
  // resp_wait cycles after acceptance before responding; starts and ends at posedge+1.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f, input int rdy_wait, input int resp_wait,
                        input logic [31:0] rd);
    int   req_seen = 0;
    int   wcnt = 0;
    logic accepted = 1'b0;
    logic captured = 1'b0;
    r_stalls = 0; r_stable = 1'b1; r_tmo = 1'b1; r_res = '0;
    r_be = '0; r_wd = '0; r_adr = '0; r_wr = 1'b0;
    data_mem_read_enable  = !wr;
    data_mem_write_enable = wr;
    data_mem_address      = a;
    data_mem_write_data   = wd;
    data_mem_format       = f;
    for (int c = 0; c < 64; c++) begin
      bus_req_ready  = bus_req_valid && (req_seen == rdy_wait);
      bus_resp_valid = accepted && (wcnt == resp_wait);
      bus_resp_rdata = bus_resp_valid ? rd : 32'h0;
      #1;
      if (bus_req_valid) begin
        if (!captured) begin
          captured = 1'b1;
          r_be = bus_req_byte_enable; r_wd = bus_req_wdata;
          r_adr = bus_req_address; r_wr = bus_req_write;
        end else if (r_be !== bus_req_byte_enable || r_wd !== bus_req_wdata ||
                     r_adr !== bus_req_address || r_wr !== bus_req_write) begin
          r_stable = 1'b0;
        end
        if (bus_req_ready) accepted = 1'b1;
        else req_seen++;
      end else if (accepted) begin
        if (bus_resp_valid) accepted = 1'b0;
        else wcnt++;
      end
      if (!want_stall) begin
        r_tmo = 1'b0;
        r_res = data_mem_read_data;
        break;
      end
      r_stalls++;
      @(posedge clock); #1;
    end
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    bus_req_ready         = 1'b0;
    bus_resp_valid        = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus_req_valid); end
    checks++; if (want_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", want_stall); end
    checks++; if (data_mem_read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", data_mem_read_data); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_load_word();
    access(1'b0, 32'h100, 32'h0, 3'b010, 0, 0, 32'hDEADBEEF);
    checks++; if (r_stalls !== 3) begin errors++; $display("FAIL lw_stalls got %0d want 3", r_stalls); end
    checks++; if (r_res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", r_res); end
    checks++; if (r_adr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", r_adr); end
    checks++; if (r_be !== 4'b1111 || r_wr !== 1'b0) begin errors++; $display("FAIL lw_be_wr got %b/%b want 1111/0", r_be, r_wr); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (data_mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold got %h want deadbeef", data_mem_read_data); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] adr [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h102};
    logic [2:0]  fmt [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000, 3'b010};
    logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                             32'hFFFFFF7F, 32'hFFFFFFFF, 32'h80FFFF7F};
    logic [3:0]  ebe [7] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
    for (int i = 0; i < 7; i++) begin
      access(1'b0, adr[i], 32'h0, fmt[i], 0, 0, 32'h80FFFF7F);
      checks++; if (r_res !== exp[i]) begin errors++; $display("FAIL sub_load[%0d] data got %h want %h", i, r_res, exp[i]); end
      checks++; if (r_be !== ebe[i] || r_adr !== 32'h100) begin errors++; $display("FAIL sub_load[%0d] be/addr got %b/%h want %b/00000100", i, r_be, r_adr, ebe[i]); end
    end
  endtask

  task automatic test_stores();
    logic [31:0] adr [3] = '{32'h202, 32'h201, 32'h307};
    logic [31:0] dat [3] = '{32'h00001234, 32'h000000AB, 32'hA5A50F0F};
    logic [2:0]  fmt [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ewd [3] = '{32'h12341234, 32'hABABABAB, 32'hA5A50F0F};
    logic [31:0] ead [3] = '{32'h200, 32'h200, 32'h304};
    logic [3:0]  ebe [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      access(1'b1, adr[i], dat[i], fmt[i], 0, 0, 32'h0);
      checks++; if (r_stalls !== 3) begin errors++; $display("FAIL st[%0d] stalls got %0d want 3", i, r_stalls); end
      checks++; if (r_wd !== ewd[i] || r_be !== ebe[i]) begin errors++; $display("FAIL st[%0d] wd/be got %h/%b want %h/%b", i, r_wd, r_be, ewd[i], ebe[i]); end
      checks++; if (r_adr !== ead[i] || r_wr !== 1'b1) begin errors++; $display("FAIL st[%0d] addr/wr got %h/%b want %h/1", i, r_adr, r_wr, ead[i]); end
    end
    checks++; if (data_mem_read_data !== 32'h80FFFF7F) begin errors++; $display("FAIL st_hold got %h want 80ffff7f", data_mem_read_data); end
  endtask

  task automatic test_backpressure();
    access(1'b0, 32'h180, 32'h0, 3'b010, 4, 0, 32'h0BADF00D);
    checks++; if (r_stalls !== 7) begin errors++; $display("FAIL rdy_stalls got %0d want 7", r_stalls); end
    checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL rdy_stable got %b want 1", r_stable); end
    checks++; if (r_res !== 32'h0BADF00D) begin errors++; $display("FAIL rdy_data got %h want 0badf00d", r_res); end
    access(1'b0, 32'h182, 32'h0, 3'b101, 0, 2, 32'hBEEF1234);
    checks++; if (r_stalls !== 5) begin errors++; $display("FAIL resp_stalls got %0d want 5", r_stalls); end
    checks++; if (r_res !== 32'h0000BEEF) begin errors++; $display("FAIL resp_data got %h want 0000beef", r_res); end
  endtask

  task automatic test_reset_in_wait();
    data_mem_read_enable = 1'b1;
    data_mem_address     = 32'h40;
    data_mem_format      = 3'b010;
    bus_req_ready        = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (bus_req_valid !== 1'b0 || want_stall !== 1'b1) begin errors++; $display("FAIL wait_state valid/stall got %b/%b want 0/1", bus_req_valid, want_stall); end
    reset = 1'b1; data_mem_read_enable = 1'b0; bus_req_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h55555555;
    #1;
    checks++; if (want_stall !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL stale_resp stall/valid got %b/%b want 0/0", want_stall, bus_req_valid); end
    @(posedge clock); #1;
    bus_resp_valid = 1'b0;
    checks++; if (data_mem_read_data !== 32'h0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL stale_rdata got %h valid %b want 0/0", data_mem_read_data, bus_req_valid); end
    access(1'b0, 32'h44, 32'h0, 3'b010, 0, 0, 32'h13579BDF);
    checks++; if (r_stalls !== 3 || r_res !== 32'h13579BDF) begin errors++; $display("FAIL post_rst_load got %0d/%h want 3/13579bdf", r_stalls, r_res); end
  endtask

`ifdef DMEM_WRITE_BUFFER_EN
  task automatic test_write_buffer();
    data_mem_write_enable = 1'b1;
    data_mem_address      = 32'h10;
    data_mem_write_data   = 32'hCAFEF00D;
    data_mem_format       = 3'b010;
    #1;
    checks++; if (want_stall !== 1'b0) begin errors++; $display("FAIL wb_sw_stall got %b want 0", want_stall); end
    @(posedge clock); #1;
    data_mem_write_enable = 1'b0; data_mem_read_enable = 1'b1;
    data_mem_address = 32'h20; bus_req_ready = 1'b1;
    #1;
    checks++; if (bus_req_valid !== 1'b1 || bus_req_write !== 1'b1 || bus_req_address !== 32'h10 || want_stall !== 1'b1)
      begin errors++; $display("FAIL wb_drain v/w/a/s got %b/%b/%h/%b want 1/1/10/1", bus_req_valid, bus_req_write, bus_req_address, want_stall); end
    @(posedge clock); #1;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
    #1;
    checks++; if (want_stall !== 1'b1) begin errors++; $display("FAIL wb_ack_stall got %b want 1", want_stall); end
    @(posedge clock); #1;
    bus_resp_valid = 1'b0;
    #1;
    checks++; if (want_stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL wb_after_ack stall/valid got %b/%b want 1/0", want_stall, bus_req_valid); end
    access(1'b0, 32'h20, 32'h0, 3'b010, 0, 0, 32'h11223344);
    checks++; if (r_stalls !== 3 || r_res !== 32'h11223344 || r_adr !== 32'h20) begin errors++; $display("FAIL wb_lw got %0d/%h/%h want 3/11223344/20", r_stalls, r_res, r_adr); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_subword_loads();
`ifdef DMEM_WRITE_BUFFER_EN
    test_write_buffer();
`else
    test_stores();
`endif
    test_backpressure();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_dmem_bridge.md
PIPELINE_DMEM_BRIDGE -- requirements
Module: pipeline_dmem_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 data_mem_read_enable  in  1  load request from the MEM stage (from the control path).
REQ-005 data_mem_write_enable  in  1  store request from the MEM stage; never asserted together with read_enable.
REQ-006 data_mem_address  in  32  byte address.
REQ-007 data_mem_write_data  in  32  store data, right-aligned.
REQ-008 data_mem_format  in  3  funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 data_mem_read_data  out  32  aligned, extended load result.
REQ-010 want_stall  out  1  stall request to the control path.
REQ-011 bus_req_valid  out  1  request valid.
REQ-012 bus_req_ready  in  1  memory accepts the request this cycle.
REQ-013 bus_req_write  out  1  1 = store.
REQ-014 bus_req_address  out  32  word address, bits [1:0] = 0.
REQ-015 bus_req_wdata  out  32  store data replicated to all byte lanes.
REQ-016 bus_req_byte_enable  out  4  lane mask.
REQ-017 bus_resp_valid  in  1  one-cycle response: load data or store acknowledge.
REQ-018 bus_resp_rdata  in  32  load word.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-020 IDLE + read or write enable: want_stall=1 combinationally; the request is latched and the FSM moves to REQ.
REQ-021 REQ: bus_req_valid=1 and want_stall=1; the bus_* request fields stay stable until bus_req_ready=1, then the FSM moves to WAIT.
REQ-022 WAIT: want_stall=1; bus_resp_valid captures the response and moves the FSM to DONE; a response is never expected in the acceptance cycle.
REQ-023 DONE: want_stall=0 and data_mem_read_data holds the result; enables are ignored this cycle; the next state is IDLE.
REQ-024 Minimum stall for a zero-wait memory SHALL be 3 cycles; each extra cycle with ready=0 or resp_valid=0 adds one stall cycle.
REQ-025 Byte enables SHALL be: byte format 0001<<addr[1:0]; halfword 0011<<(2*addr[1]); word 1111. Misaligned low bits SHALL be ignored, with no trap.
REQ-026 Loads SHALL extract the byte or halfword selected by the latched address; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-027 data_mem_read_data SHALL hold its value until the next load completes.

Reset
REQ-028 Reset SHALL force IDLE, bus_req_valid=0, want_stall=0, data_mem_read_data=0, and an empty write buffer.
REQ-029 Reset during REQ or WAIT SHALL abandon the access; a response arriving after reset SHALL be ignored in IDLE.

Configuration
REQ-030 Macro DMEM_WRITE_BUFFER_EN SHALL enable or disable the one-entry write buffer.
REQ-031 Without the macro, stores SHALL follow the IDLE→REQ→WAIT→DONE sequence exactly as loads do.
REQ-032 With the macro, a store seen in IDLE with an empty buffer SHALL be buffered with want_stall=0, then drained on the bus.
REQ-033 With the macro, a load or store arriving while the buffer is non-empty SHALL stall until the buffer's acknowledge, then proceed normally.

Structure
REQ-034 The FSM state enum and the load/store format codes SHALL go in the shared constants package.
REQ-035 Lane steering and extension SHALL live in the combinational sub-module load_store_align.

Verification
REQ-036 LW at 0x100 with ready=1 and resp 1 cycle later, rdata=0xDEADBEEF -> want_stall high for 3 cycles, then read_data=0xDEADBEEF with want_stall=0.
REQ-037 LB at 0x103 with rdata=0x80FF_FF7F -> read_data=0xFFFFFF80; LBU at the same address -> read_data=0x00000080.
REQ-038 SH at 0x202 with data 0x1234 -> byte_enable=1100, wdata=0x12341234, bus address 0x200.
REQ-039 ready held low for 4 cycles -> valid and request fields stable throughout, stall extended by 4 cycles.
REQ-040 DMEM_WRITE_BUFFER_EN: SW then an immediate LW -> SW causes no stall; LW stalls until the SW acknowledge, then issues.
REQ-041 Reset asserted in WAIT, then a stale resp_valid -> FSM in IDLE, no outputs change, next load completes normally.
